bus_select_encode: RTL and testbench
====================================

Name: bus_select_encode

Overview:
- Destination/source-select side of the shared 32-bit datapath bus. The bus is a priority mux driven by one-hot out-enables and is undefined when more than one is asserted.
- Latches the instruction word from the bus and decodes its register fields into one-hot register in-enables and out-enables.
- Produces the sign-extended constant that is driven onto the bus through the CSign source.
- Contains a small move sequencer that performs bus-to-register transfers, with a request/busy/done handshake, for control-unit microsteps.

Parameters:
- IR_RA_LSB, 23, LSB of 4-bit ra field (ra = IR[26:23])
- IR_RB_LSB, 19, LSB of 4-bit rb field (rb = IR[22:19])
- IR_RC_LSB, 15, LSB of 4-bit rc field (rc = IR[18:15])
- CONST_W, 19, width of the immediate C = IR[CONST_W-1:0]

Ports:
- clock  in  1  system clock, all state on rising edge
- clear  in  1  synchronous active-high reset
- IRin  in  1  load ir_q from bus_in at the edge
- bus_in  in  32  bus mux output
- Gra, Grb, Grc  in  1 each  field select for decode
- Rin, Rout, BAout  in  1 each  decode strobes
- xfer_req  in  1  move request, sampled only in IDLE
- xfer_src  in  5  source code: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 ZMux, 21 PC, 22 MDR, 23 PortIn, 24 CSign
- xfer_dst  in  4  destination register R0-R15
- Rin_en  out  16  one-hot register in-enables
- Rout_en  out  16  one-hot register out-enables
- aux_out_en  out  9  one-hot out-enables, bit0..8 = HI, LO, ZHI, ZLO, ZMux, PC, MDR, PortIn, CSign
- r0_zero  out  1  R0 reads as zero (BAout on R0)
- c_sign_ext  out  32  sign-extended C
- ir_q  out  32  latched instruction
- xfer_busy  out  1  sequencer not IDLE
- xfer_done  out  1  one-cycle completion pulse
- xfer_err  out  1  one-cycle pulse, illegal xfer_src (25-31)

Behaviour:
- Reset (clear=1 at edge):
  - ir_q = 0, state = IDLE.
  - All sequencer enables, xfer_done and xfer_err = 0.
  - All outputs read 0 the cycle after reset, because decode of ir_q = 0 with strobes low gives 0.
  - Reset mid-transfer aborts immediately. No done pulse.
- IR latch: if IRin=1 at an edge, ir_q <= bus_in. Otherwise ir_q holds. clear has priority over IRin.
- Decode path (combinational from ir_q and strobes):
  - sel = ra if Gra, else rb if Grb, else rc if Grc. Priority is Gra > Grb > Grc.
  - With no Gr asserted, the decode path outputs 0.
  - Rin_en[sel] = Rin.
  - Rout_en[sel] = Rout | BAout, except when BAout=1 and sel=0: Rout_en[0]=0 and r0_zero=1.
  - c_sign_ext = {13{ir_q[18]}, ir_q[18:0]}, continuous.
- Sequencer FSM, states IDLE, DRIVE, LATCH:
  - IDLE: on xfer_req=1 with xfer_src <= 24, capture src and dst and go to DRIVE.
  - IDLE: on xfer_req=1 with xfer_src > 24, pulse xfer_err next cycle and stay in IDLE.
  - DRIVE (1 cycle): registered out-enable for src asserted. Bus settles.
  - LATCH (1 cycle): same out-enable held, and Rin_en[dst] asserted. The destination captures at the end of LATCH. xfer_done=1 during LATCH. Next state is IDLE.
  - Latency: request edge -> out-enable visible 1 cycle later -> done 2 cycles later. Back-to-back requests accepted every 3 cycles.
  - xfer_req while busy is ignored and not queued.
  - xfer_busy = (state != IDLE).
- Output merge: final enables = sequencer enables OR decode enables. The decode path is forced to 0 while xfer_busy=1, so at most one out-enable is ever active.
- Source equals destination (e.g. R4->R4) is legal and performs the normal 3-cycle sequence.

Decomposition:
- Shared package bus_pkg holds:
  - source-code constants SRC_R0..SRC_CSIGN (0-24) and SRC_LAST=24
  - aux_out_en bit indices
  - FSM state enum (IDLE=0, DRIVE=1, LATCH=2)
  - IR field LSB constants
- One sub-module is natural: reg_decode_4to16 (4-bit index plus enable to one-hot 16). It is instantiated for the Rin path, the Rout path and the sequencer destination.

Test Plan:
- Decode fields: bus_in=0x029B8000, IRin=1, then Gra=1 with Rin=1 -> Rin_en=0x0020 (R5). Grb with Rout=1 -> Rout_en=0x0008. Grc with Rout=1 -> Rout_en=0x0080.
- Sign extension: ir_q=0x0007FFFF -> c_sign_ext=0xFFFFFFFF. ir_q=0x00040000 -> 0xFFFC0000. ir_q=0x0003FFFF -> 0x0003FFFF.
- R0 zero: ir_q ra=0, Gra=1, BAout=1 -> Rout_en=0, r0_zero=1. Same with Rout=1 and BAout=0 -> Rout_en=0x0001, r0_zero=0.
- Move: xfer_req with src=22 (MDR), dst=9 -> cycle+1 aux_out_en=0x040 and busy=1. Cycle+2 also Rin_en=0x0200 and done=1. Cycle+3 idle, all enables 0. Decode strobes asserted meanwhile have no effect.
- Illegal and ignored requests: xfer_src=27 -> xfer_err pulses 1 cycle, no enables, busy stays 0. A second xfer_req during DRIVE is dropped, so exactly one done pulse occurs.
- Reset mid-transfer: clear=1 during DRIVE -> next cycle all outputs 0, busy=0, no done pulse. ir_q=0 even if IRin=1 at the same edge.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, source codes and sequencer states for the bus select/encode block
package bus_pkg;

  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;
  localparam int CONST_W   = 19;

  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLO    = 5'd19;
  localparam logic [4:0] SRC_ZMUX   = 5'd20;
  localparam logic [4:0] SRC_PC     = 5'd21;
  localparam logic [4:0] SRC_MDR    = 5'd22;
  localparam logic [4:0] SRC_PORTIN = 5'd23;
  localparam logic [4:0] SRC_CSIGN  = 5'd24;
  localparam logic [4:0] SRC_LAST   = 5'd24;

  localparam int AUX_HI     = 0;
  localparam int AUX_LO     = 1;
  localparam int AUX_ZHI    = 2;
  localparam int AUX_ZLO    = 3;
  localparam int AUX_ZMUX   = 4;
  localparam int AUX_PC     = 5;
  localparam int AUX_MDR    = 6;
  localparam int AUX_PORTIN = 7;
  localparam int AUX_CSIGN  = 8;
  localparam int AUX_W      = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2
  } xfer_state_t;

endpackage

// File: rtl/reg_decode_4to16.sv
// rtl/reg_decode_4to16.sv - 4-bit register index plus enable to one-hot 16
module reg_decode_4to16 (
  input  logic [3:0]  idx_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  assign onehot_o = en_i ? (16'd1 << idx_i) : 16'd0;

endmodule

// File: rtl/bus_select_encode.sv
// rtl/bus_select_encode.sv - IR latch, register-field decode, constant sign extension and move sequencer
module bus_select_encode
  import bus_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        IRin,
  input  logic [31:0] bus_in,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        xfer_req,
  input  logic [4:0]  xfer_src,
  input  logic [3:0]  xfer_dst,
  output logic [15:0] Rin_en,
  output logic [15:0] Rout_en,
  output logic [8:0]  aux_out_en,
  output logic        r0_zero,
  output logic [31:0] c_sign_ext,
  output logic [31:0] ir_q,
  output logic        xfer_busy,
  output logic        xfer_done,
  output logic        xfer_err
);

  xfer_state_t state_q, state_d;
  logic [4:0]  src_q, src_d;
  logic [3:0]  dst_q, dst_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer_req) begin
          if (xfer_src <= SRC_LAST) begin
            src_d   = xfer_src;
            dst_d   = xfer_dst;
            state_d = ST_DRIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DRIVE: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      ir_q    <= 32'd0;
      state_q <= ST_IDLE;
      src_q   <= 5'd0;
      dst_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      if (IRin) begin
        ir_q <= bus_in;
      end
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
    end
  end

  logic       busy;
  logic       dec_en;
  logic [3:0] sel;
  logic       sel_r0;
  logic       dec_rin_en;
  logic       dec_rout_en;
  logic       seq_reg_src;
  logic [4:0] aux_idx;

  assign busy   = (state_q != ST_IDLE);
  assign dec_en = (Gra | Grb | Grc) & ~busy;
  assign sel    = Gra ? ir_q[IR_RA_LSB +: 4] :
                  Grb ? ir_q[IR_RB_LSB +: 4] :
                        ir_q[IR_RC_LSB +: 4];
  assign sel_r0 = (sel == 4'd0);

  // BAout on R0 substitutes a zero for the register instead of driving it
  assign dec_rin_en  = dec_en & Rin;
  assign dec_rout_en = dec_en & (Rout | BAout) & ~(BAout & sel_r0);
  assign r0_zero     = dec_en & BAout & sel_r0;

  // Decode is silenced while busy, so sharing one Rout decoder equals ORing both paths
  assign seq_reg_src = busy & ~src_q[4];

  reg_decode_4to16 u_rout_dec (
    .idx_i    (busy ? src_q[3:0] : sel),
    .en_i     (busy ? seq_reg_src : dec_rout_en),
    .onehot_o (Rout_en)
  );

  logic [15:0] rin_dec;
  logic [15:0] rin_seq;

  reg_decode_4to16 u_rin_dec (
    .idx_i    (sel),
    .en_i     (dec_rin_en),
    .onehot_o (rin_dec)
  );

  reg_decode_4to16 u_dst_dec (
    .idx_i    (dst_q),
    .en_i     (state_q == ST_LATCH),
    .onehot_o (rin_seq)
  );

  assign Rin_en = rin_dec | rin_seq;

  assign aux_idx    = src_q - SRC_HI;
  assign aux_out_en = (busy & src_q[4]) ? (9'd1 << aux_idx) : 9'd0;

  assign c_sign_ext = {{(32 - CONST_W){ir_q[CONST_W-1]}}, ir_q[CONST_W-1:0]};

  assign xfer_busy = busy;
  assign xfer_done = (state_q == ST_LATCH);
  assign xfer_err  = err_q;

endmodule

// File: tb/tb_bus_select_encode.sv
// tb/tb_bus_select_encode.sv - scoreboard bench for bus_select_encode
module tb_bus_select_encode;
  import bus_pkg::*;

  logic        clock = 1'b0;
  logic        clear, IRin, Gra, Grb, Grc, Rin, Rout, BAout, xfer_req;
  logic [31:0] bus_in;
  logic [4:0]  xfer_src;
  logic [3:0]  xfer_dst;
  logic [15:0] Rin_en, Rout_en;
  logic [8:0]  aux_out_en;
  logic        r0_zero, xfer_busy, xfer_done, xfer_err;
  logic [31:0] c_sign_ext, ir_q;

  bus_select_encode dut (
    .clock(clock), .clear(clear), .IRin(IRin), .bus_in(bus_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .xfer_req(xfer_req), .xfer_src(xfer_src), .xfer_dst(xfer_dst),
    .Rin_en(Rin_en), .Rout_en(Rout_en), .aux_out_en(aux_out_en), .r0_zero(r0_zero),
    .c_sign_ext(c_sign_ext), .ir_q(ir_q), .xfer_busy(xfer_busy),
    .xfer_done(xfer_done), .xfer_err(xfer_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           cyc;
    string        name;
    logic [108:0] vec;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ir_m = 32'd0;
  logic [31:0] csx_m = 32'd0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compares every expectation scheduled for the current cycle
  always @(negedge clock) begin
    logic [108:0] act;
    exp_t e;
    act = {Rin_en, Rout_en, aux_out_en, r0_zero, xfer_busy, xfer_done, xfer_err, c_sign_ext, ir_q};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (act !== e.vec) begin
        errors++;
        $display("FAIL %s: got rin=%h rout=%h aux=%h r0z=%b busy=%b done=%b err=%b csx=%h ir=%h, want rin=%h rout=%h aux=%h r0z=%b busy=%b done=%b err=%b csx=%h ir=%h",
                 e.name, act[108:93], act[92:77], act[76:68], act[67], act[66], act[65], act[64], act[63:32], act[31:0],
                 e.vec[108:93], e.vec[92:77], e.vec[76:68], e.vec[67], e.vec[66], e.vec[65], e.vec[64], e.vec[63:32], e.vec[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [15:0] rin, input logic [15:0] rout,
                            input logic [8:0] aux, input logic r0z, input logic busy,
                            input logic done, input logic err);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.vec  = {rin, rout, aux, r0z, busy, done, err, csx_m, ir_m};
    sb.push_back(e);
  endtask

  task automatic load_ir(input logic [31:0] v, input logic [31:0] csx);
    IRin   = 1'b1;
    bus_in = v;
    step();
    IRin   = 1'b0;
    ir_m   = v;
    csx_m  = csx;
  endtask

  task automatic strobes(input logic a, input logic b, input logic c,
                         input logic ri, input logic ro, input logic ba);
    Gra = a; Grb = b; Grc = c; Rin = ri; Rout = ro; BAout = ba;
  endtask

  task automatic request(input logic [4:0] src, input logic [3:0] dst);
    xfer_req = 1'b1;
    xfer_src = src;
    xfer_dst = dst;
  endtask

  initial begin
    clear = 1'b1; IRin = 1'b0; bus_in = 32'd0; xfer_req = 1'b0; xfer_src = 5'd0; xfer_dst = 4'd0;
    strobes(0, 0, 0, 0, 0, 0);
    step();
    step();
    clear = 1'b0;
    expect_out("reset", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();

    load_ir(32'h029B8000, 32'h00038000);
    strobes(1, 0, 0, 1, 0, 0);
    expect_out("dec_ra_rin", 16'h0020, 16'h0, 9'h0, 0, 0, 0, 0);
    step();
    strobes(0, 1, 0, 0, 1, 0);
    expect_out("dec_rb_rout", 16'h0, 16'h0008, 9'h0, 0, 0, 0, 0);
    step();
    strobes(0, 0, 1, 0, 1, 0);
    expect_out("dec_rc_rout", 16'h0, 16'h0080, 9'h0, 0, 0, 0, 0);
    step();
    strobes(1, 1, 1, 0, 1, 0);
    expect_out("dec_priority", 16'h0, 16'h0020, 9'h0, 0, 0, 0, 0);
    step();
    strobes(0, 0, 1, 0, 0, 1);
    expect_out("dec_baout_nonzero", 16'h0, 16'h0080, 9'h0, 0, 0, 0, 0);
    step();
    strobes(0, 0, 0, 1, 1, 1);
    expect_out("dec_no_gr", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();
    strobes(0, 0, 0, 0, 0, 0);

    load_ir(32'h0007FFFF, 32'hFFFFFFFF);
    expect_out("sext_all_ones", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();
    load_ir(32'h00040000, 32'hFFFC0000);
    expect_out("sext_sign_only", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();
    load_ir(32'h0003FFFF, 32'h0003FFFF);
    expect_out("sext_max_pos", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();

    strobes(1, 0, 0, 0, 0, 1);
    expect_out("r0_baout", 16'h0, 16'h0, 9'h0, 1, 0, 0, 0);
    step();
    strobes(1, 0, 0, 0, 1, 0);
    expect_out("r0_rout", 16'h0, 16'h0001, 9'h0, 0, 0, 0, 0);
    step();
    strobes(0, 0, 0, 0, 0, 0);

    // MDR -> R9 with decode strobes active during the transfer
    request(SRC_MDR, 4'd9);
    expect_out("mv_mdr_req", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();
    xfer_req = 1'b0;
    strobes(1, 0, 0, 1, 1, 0);
    expect_out("mv_mdr_drive", 16'h0, 16'h0, 9'h040, 0, 1, 0, 0);
    step();
    expect_out("mv_mdr_latch", 16'h0200, 16'h0, 9'h040, 0, 1, 1, 0);
    step();
    strobes(0, 0, 0, 0, 0, 0);
    expect_out("mv_mdr_idle", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();

    request(5'd4, 4'd4);
    step();
    xfer_req = 1'b0;
    expect_out("mv_r4_drive", 16'h0, 16'h0010, 9'h0, 0, 1, 0, 0);
    step();
    expect_out("mv_r4_latch", 16'h0010, 16'h0010, 9'h0, 0, 1, 1, 0);
    step();

    request(SRC_CSIGN, 4'd15);
    step();
    request(SRC_HI, 4'd0);
    expect_out("mv_csign_drive", 16'h0, 16'h0, 9'h100, 0, 1, 0, 0);
    step();
    xfer_req = 1'b0;
    expect_out("mv_csign_latch", 16'h8000, 16'h0, 9'h100, 0, 1, 1, 0);
    step();
    expect_out("mv_dropped_idle", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();
    expect_out("mv_dropped_none", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();

    request(SRC_HI, 4'd2);
    step();
    xfer_req = 1'b0;
    expect_out("mv_hi_drive", 16'h0, 16'h0, 9'h001, 0, 1, 0, 0);
    step();
    expect_out("mv_hi_latch", 16'h0004, 16'h0, 9'h001, 0, 1, 1, 0);
    step();

    request(5'd27, 4'd3);
    step();
    xfer_req = 1'b0;
    expect_out("illegal_27_err", 16'h0, 16'h0, 9'h0, 0, 0, 0, 1);
    step();
    expect_out("illegal_27_after", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();
    request(5'd25, 4'd3);
    step();
    request(5'd31, 4'd3);
    expect_out("illegal_25_err", 16'h0, 16'h0, 9'h0, 0, 0, 0, 1);
    step();
    xfer_req = 1'b0;
    expect_out("illegal_31_err", 16'h0, 16'h0, 9'h0, 0, 0, 0, 1);
    step();

    // Reset during DRIVE, with an IR load at the same edge
    request(SRC_PC, 4'd6);
    step();
    xfer_req = 1'b0;
    clear = 1'b1; IRin = 1'b1; bus_in = 32'hFFFFFFFF;
    expect_out("rst_mid_drive", 16'h0, 16'h0, 9'h020, 0, 1, 0, 0);
    step();
    clear = 1'b0; IRin = 1'b0;
    ir_m = 32'd0; csx_m = 32'd0;
    expect_out("rst_mid_after", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();
    expect_out("rst_mid_nodone", 16'h0, 16'h0, 9'h0, 0, 0, 0, 0);
    step();
    step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
